rx_frame_ctrl: RTL and testbench
================================

# rx_frame_ctrl

Receive-side controller for the serial link. It generates the 16x-oversample `tick` that paces the byte receiver and collects the receiver's `dout`/`load` byte stream. It parses the stream into 4-byte command frames (sync, cmd, arg, checksum) and presents each validated command to game logic over a valid/ready handshake. It sits between the byte receiver and the game-state controller and holds a running error count.

## Interface
Parameters:
- `CLK_DIV`, default 326: clocks per tick. Gives 16x oversampling at 9600 baud from 50 MHz.
- `TIMEOUT_TICKS`, default 4096: inter-byte timeout measured in ticks.
- `SYNC_BYTE`, default 8'hA5: frame start marker.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `tick` out 1: one-cycle pulse every `CLK_DIV` clocks, driven to the byte receiver.
- `byte_in` in 8: received byte, meaningful only when `byte_load` is high.
- `byte_load` in 1: one-cycle strobe from the receiver.
- `cmd_valid` out 1: a command is held for the consumer.
- `cmd_ready` in 1: the consumer accepts the command.
- `cmd` out 8: command byte of the held frame.
- `arg` out 8: argument byte of the held frame.
- `err_cnt` out 8: saturating count of checksum and timeout errors.
- `overrun` out 1: one-cycle pulse when a valid frame is dropped because the holding register is full.

## Operation
- **Divider.** `div_cnt` counts 0..`CLK_DIV`-1 and wraps. `tick` is high in the cycle where `div_cnt`==`CLK_DIV`-1. The divider free-runs in every state.
- **Parser FSM.** States are IDLE, GOT_SYNC, GOT_CMD, GOT_ARG. Every transition below happens only on `byte_load`.
  - IDLE: `byte_in`==`SYNC_BYTE` -> GOT_SYNC. Any other byte is ignored; no error is counted.
  - GOT_SYNC: latch `byte_in` into `cmd_tmp` -> GOT_CMD.
  - GOT_CMD: latch `byte_in` into `arg_tmp` -> GOT_ARG.
  - GOT_ARG: compare `byte_in` against `cmd_tmp ^ arg_tmp`, then return to IDLE in every case.
    - Match and holding register free: load `cmd`/`arg`, set `cmd_valid`.
    - Match and holding register full: pulse `overrun` and drop the frame.
    - Mismatch: increment `err_cnt`.
- **Holding register.** "Free" means `cmd_valid`==0, or `cmd_valid && cmd_ready` in the same cycle. This allows back-to-back refill.
- **Handshake.** `cmd` and `arg` stay stable while `cmd_valid` is high. A transfer occurs when `cmd_valid && cmd_ready`. `cmd_valid` then clears next cycle unless a new frame loads in that same cycle.
- **Error counter.** `err_cnt` saturates at 255. A checksum error and a timeout never occur in the same cycle, because `byte_load` takes priority over the timeout.
- **Reset mid-frame.** Asserting `reset` forces the FSM to IDLE and discards partial frames immediately (asynchronous).

## Timing
- Reset values:
  - `tick`=0, `cmd_valid`=0, `cmd`=0, `arg`=0, `err_cnt`=0, `overrun`=0.
  - FSM=IDLE, `div_cnt`=0, timeout counter=0.
- First `tick` occurs `CLK_DIV` clocks after `reset` deasserts.
- Latency: `cmd_valid` rises one clock after the `byte_load` that carries the checksum byte.
- Error timing: `err_cnt` updates, and `overrun` pulses, one clock after that same `byte_load`.
- `byte_load` is assumed to be at most one cycle per tick. Consecutive `byte_load` cycles are each consumed.

## Configuration
- `RX_FRAME_TIMEOUT_EN` defined:
  - A tick-counter runs while the FSM is not in IDLE and clears on every `byte_load`.
  - On reaching `TIMEOUT_TICKS`-1 with a `tick`, the FSM returns to IDLE and `err_cnt` increments (saturating).
- `RX_FRAME_TIMEOUT_EN` undefined: no timeout counter. A partial frame waits indefinitely for its remaining bytes.

## Structure
- Package `rx_frame_pkg`:
  - FSM state typedef (IDLE/GOT_SYNC/GOT_CMD/GOT_ARG).
  - Default `SYNC_BYTE` constant.
  - `ERR_CNT_MAX`=8'hFF.
- Sub-module `baud_tick_gen`: parameter `CLK_DIV`; ports `clk`, `reset`, `tick`. It is instantiated once.
- The FSM, holding register, error logic and optional timeout stay in `rx_frame_ctrl`.

## Test plan
- Clean frame: bytes A5,12,34,26 with `cmd_ready`=1 -> `cmd_valid` for one cycle, `cmd`=12, `arg`=34, `err_cnt`=0.
- Bad checksum: bytes A5,12,34,00 -> no `cmd_valid`, `err_cnt`=1; a following good frame A5,01,02,03 is delivered.
- Back-pressure: `cmd_ready`=0, send A5,12,34,26 then A5,55,AA,FF -> first frame held, `overrun` pulses once, `cmd` stays 12. Raising `cmd_ready` and then sending A5,55,AA,FF makes that frame visible.
- Noise and saturation: bytes 00,FF,A4 before A5,.. -> ignored, no error. Then 300 bad-checksum frames -> `err_cnt`=255 and holds.
- Timeout (with `RX_FRAME_TIMEOUT_EN`, `TIMEOUT_TICKS`=16): send A5,12 then stop -> after 16 ticks `err_cnt`=1, FSM in IDLE. Next A5,01,02,03 is delivered.
- Reset mid-frame: send A5,12, pulse `reset` low, then send 34,26 -> no command output; `tick` restarts `CLK_DIV` clocks after release.

Source files
------------

// File: rtl/rx_frame_pkg.sv
// -----------------------------------------------------------------------------
// rx_frame_pkg
// Shared definitions for the receive-side frame controller:
//   - rx_state_e        : parser state encoding (IDLE/GOT_SYNC/GOT_CMD/GOT_ARG)
//   - SYNC_BYTE_DEFAULT : default frame start marker
//   - ERR_CNT_MAX       : saturation value of the error counter
//   - frame_csum()      : checksum carried in the fourth byte of a frame
//   - err_sat_inc()     : saturating increment for the error counter
// -----------------------------------------------------------------------------
package rx_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GOT_SYNC = 2'd1,
    ST_GOT_CMD  = 2'd2,
    ST_GOT_ARG  = 2'd3
  } rx_state_e;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam logic [7:0] ERR_CNT_MAX       = 8'hFF;

  // The checksum byte is the XOR of the command and argument bytes.
  function automatic logic [7:0] frame_csum(input logic [7:0] cmd_b,
                                            input logic [7:0] arg_b);
    return cmd_b ^ arg_b;
  endfunction

  // Error counter sticks at its maximum instead of wrapping.
  function automatic logic [7:0] err_sat_inc(input logic [7:0] val);
    return (val == ERR_CNT_MAX) ? val : val + 8'd1;
  endfunction

endpackage : rx_frame_pkg

// File: rtl/baud_tick_gen.sv
// -----------------------------------------------------------------------------
// baud_tick_gen
// Free-running clock divider producing the 16x-oversample tick for the byte
// receiver. div_cnt counts 0..CLK_DIV-1 and wraps; tick is high in exactly the
// cycle where div_cnt equals CLK_DIV-1.
//
// Parameters:
//   CLK_DIV : clocks per tick (>= 2)
// Ports:
//   clk   in  : clock
//   reset in  : asynchronous, active-low reset
//   tick  out : one-cycle pulse every CLK_DIV clocks
// -----------------------------------------------------------------------------
module baud_tick_gen #(
  parameter int CLK_DIV = 326
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int            CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    div_cnt_d = (div_cnt_q == CNT_LAST) ? '0 : div_cnt_q + 1'b1;
    // tick is registered, but computed from the next count so that the flop
    // is high in the same cycle div_cnt_q sits at CNT_LAST.
    tick_d    = (div_cnt_d == CNT_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      tick_q    <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule : baud_tick_gen

// File: rtl/rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// rx_frame_ctrl
// Receive-side controller for the serial link. Generates the oversample tick
// for the byte receiver, parses the received byte stream into 4-byte frames
// (sync, cmd, arg, checksum) and presents each validated command over a
// valid/ready handshake. Keeps a saturating count of checksum/timeout errors.
//
// Optional feature (compile-time macro RX_FRAME_TIMEOUT_EN):
//   defined   : a partial frame is abandoned after TIMEOUT_TICKS ticks without
//               a new byte, and the abandonment counts as an error.
//   undefined : a partial frame waits indefinitely for its remaining bytes.
//
// Parameters:
//   CLK_DIV       : clocks per tick
//   TIMEOUT_TICKS : inter-byte timeout in ticks (>= 2)
//   SYNC_BYTE     : frame start marker
// Ports:
//   clk       in  : clock
//   reset     in  : asynchronous, active-low reset
//   tick      out : oversample tick to the byte receiver
//   byte_in   in  : received byte, qualified by byte_load
//   byte_load in  : one-cycle byte strobe
//   cmd_valid out : a command is held for the consumer
//   cmd_ready in  : consumer accepts the held command
//   cmd       out : command byte of the held frame
//   arg       out : argument byte of the held frame
//   err_cnt   out : saturating checksum/timeout error count
//   overrun   out : pulse when a good frame is dropped (holding reg full)
// -----------------------------------------------------------------------------
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter int         CLK_DIV       = 326,
  parameter int         TIMEOUT_TICKS = 4096,
  parameter logic [7:0] SYNC_BYTE     = SYNC_BYTE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  output logic       tick,
  input  logic [7:0] byte_in,
  input  logic       byte_load,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd,
  output logic [7:0] arg,
  output logic [7:0] err_cnt,
  output logic       overrun
);

  // ---------------------------------------------------------------------------
  // Tick generator
  // ---------------------------------------------------------------------------
  baud_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_baud_tick_gen (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  rx_state_e  state_q, state_d;
  logic [7:0] cmd_tmp_q, cmd_tmp_d;
  logic [7:0] arg_tmp_q, arg_tmp_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] arg_q, arg_d;
  logic       cmd_valid_q, cmd_valid_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       overrun_q, overrun_d;

  logic       hold_free;
  logic       timeout_hit;
  logic       err_inc;

  // The holding register can take a new frame when empty, or when the held
  // command is being consumed in this same cycle (back-to-back refill).
  assign hold_free = !cmd_valid_q || cmd_ready;

  // ---------------------------------------------------------------------------
  // Optional inter-byte timeout
  // ---------------------------------------------------------------------------
`ifdef RX_FRAME_TIMEOUT_EN
  localparam int              TO_W    = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // byte_load wins over the timeout, so a checksum error and a timeout
  // error never land in the same cycle.
  assign timeout_hit = (state_q != ST_IDLE) && tick && !byte_load &&
                       (to_cnt_q == TO_LAST);

  always_comb begin
    to_cnt_d = to_cnt_q;
    if ((state_q == ST_IDLE) || byte_load) begin
      to_cnt_d = '0;
    end else if (tick) begin
      to_cnt_d = (to_cnt_q == TO_LAST) ? '0 : to_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_d;
    end
  end
`else
  // Without the timeout the parameter only documents the interface.
  logic unused_timeout_ticks;
  assign unused_timeout_ticks = ^TIMEOUT_TICKS;
  assign timeout_hit          = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Parser, holding register and error logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cmd_tmp_d = cmd_tmp_q;
    arg_tmp_d = arg_tmp_q;
    cmd_d     = cmd_q;
    arg_d     = arg_q;
    // A transfer empties the holding register unless a frame refills it below.
    cmd_valid_d = cmd_valid_q && !cmd_ready;
    overrun_d   = 1'b0;
    err_inc     = 1'b0;

    if (byte_load) begin
      unique case (state_q)
        ST_IDLE: begin
          // Anything other than the marker is line noise and is ignored.
          if (byte_in == SYNC_BYTE) begin
            state_d = ST_GOT_SYNC;
          end
        end
        ST_GOT_SYNC: begin
          cmd_tmp_d = byte_in;
          state_d   = ST_GOT_CMD;
        end
        ST_GOT_CMD: begin
          arg_tmp_d = byte_in;
          state_d   = ST_GOT_ARG;
        end
        ST_GOT_ARG: begin
          state_d = ST_IDLE;
          if (byte_in == frame_csum(cmd_tmp_q, arg_tmp_q)) begin
            if (hold_free) begin
              cmd_d       = cmd_tmp_q;
              arg_d       = arg_tmp_q;
              cmd_valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            err_inc = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timeout_hit) begin
      state_d = ST_IDLE;
      err_inc = 1'b1;
    end

    err_cnt_d = err_inc ? err_sat_inc(err_cnt_q) : err_cnt_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cmd_tmp_q   <= 8'h00;
      arg_tmp_q   <= 8'h00;
      cmd_q       <= 8'h00;
      arg_q       <= 8'h00;
      cmd_valid_q <= 1'b0;
      err_cnt_q   <= 8'h00;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_tmp_q   <= cmd_tmp_d;
      arg_tmp_q   <= arg_tmp_d;
      cmd_q       <= cmd_d;
      arg_q       <= arg_d;
      cmd_valid_q <= cmd_valid_d;
      err_cnt_q   <= err_cnt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd       = cmd_q;
  assign arg       = arg_q;
  assign err_cnt   = err_cnt_q;
  assign overrun   = overrun_q;

endmodule : rx_frame_ctrl

// File: tb/tb_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rx_frame_ctrl
// Directed and randomized stimulus for rx_frame_ctrl, checked cycle by cycle
// against a frame-level reference model (byte queue + expected outputs).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rx_frame_ctrl;

  localparam int         CLK_DIV       = 8;
  localparam int         TIMEOUT_TICKS = 16;
  localparam logic [7:0] SYNC          = 8'hA5;

  logic       clk;
  logic       reset;
  logic       tick;
  logic [7:0] byte_in;
  logic       byte_load;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd;
  logic [7:0] arg;
  logic [7:0] err_cnt;
  logic       overrun;

  rx_frame_ctrl #(
    .CLK_DIV       (CLK_DIV),
    .TIMEOUT_TICKS (TIMEOUT_TICKS),
    .SYNC_BYTE     (SYNC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .byte_in   (byte_in),
    .byte_load (byte_load),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .arg       (arg),
    .err_cnt   (err_cnt),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  frame_q[$];
  int unsigned edges;        // clock edges since reset release
  int unsigned wait_ticks;   // ticks seen since the last byte of a partial frame
  logic        exp_valid;
  logic [7:0]  exp_cmd, exp_arg, exp_err;
  logic        exp_ovr, exp_tick;

  // Observation counters for directed sections
  int ovr_seen;
  int valid_rises;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] sat(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  task automatic model_reset();
    frame_q.delete();
    edges = 0; wait_ticks = 0;
    exp_valid = 0; exp_cmd = 0; exp_arg = 0; exp_err = 0; exp_ovr = 0; exp_tick = 0;
  endtask

  // Predict the outputs after the coming edge from the inputs of this cycle.
  task automatic model_edge(input bit ld, input logic [7:0] b, input bit rdy);
    bit tick_now;
    bit free;
    bit nv;
    tick_now = ((edges % CLK_DIV) == CLK_DIV - 1);
    free     = !exp_valid || rdy;
    nv       = exp_valid && !rdy;
    exp_ovr  = 0;
    if (ld) begin
      wait_ticks = 0;
      if (frame_q.size() == 0) begin
        if (b == SYNC) frame_q.push_back(b);
      end else begin
        frame_q.push_back(b);
        if (frame_q.size() == 4) begin
          if (frame_q[3] == (frame_q[1] ^ frame_q[2])) begin
            if (free) begin
              exp_cmd = frame_q[1];
              exp_arg = frame_q[2];
              nv = 1;
            end else begin
              exp_ovr = 1;
            end
          end else begin
            exp_err = sat(exp_err);
          end
          frame_q.delete();
        end
      end
    end else if (frame_q.size() != 0 && tick_now) begin
      wait_ticks++;
`ifdef RX_FRAME_TIMEOUT_EN
      if (wait_ticks == TIMEOUT_TICKS) begin
        frame_q.delete();
        wait_ticks = 0;
        exp_err = sat(exp_err);
      end
`endif
    end
    exp_valid = nv;
    edges++;
    exp_tick = ((edges % CLK_DIV) == CLK_DIV - 1);
  endtask

  // One clock cycle: drive, predict, clock, compare.
  task automatic step(input bit ld, input logic [7:0] b, input bit rdy);
    byte_load = ld;
    byte_in   = b;
    cmd_ready = rdy;
    model_edge(ld, b, rdy);
    @(posedge clk);
    #1;
    byte_load = 0;
    check("tick", tick, exp_tick);
    check("cmd_valid", cmd_valid, exp_valid);
    check("cmd", cmd, exp_cmd);
    check("arg", arg, exp_arg);
    check("err_cnt", err_cnt, exp_err);
    check("overrun", overrun, exp_ovr);
    if (overrun) ovr_seen++;
    if (cmd_valid && exp_valid) valid_rises++;
    $display("cyc %0d ld=%0b b=%02h rdy=%0b -> valid=%0b cmd=%02h arg=%02h err=%0d ovr=%0b tick=%0b",
             edges, ld, b, rdy, cmd_valid, cmd, arg, err_cnt, overrun, tick);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit rdy);
    int gap;
    gap = $urandom_range(0, 2);
    for (int i = 0; i < gap; i++) step(0, 8'h00, rdy);
    step(1, b, rdy);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] a,
                            input logic [7:0] cs, input bit rdy);
    send_byte(SYNC, rdy);
    send_byte(c, rdy);
    send_byte(a, rdy);
    send_byte(cs, rdy);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 0;
    #1;
    // Reset acts without waiting for a clock edge.
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd", cmd, 0);
    check("rst_arg", arg, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_overrun", overrun, 0);
    check("rst_tick", tick, 0);
    repeat (2) @(posedge clk);
    #3 reset = 1;
    model_reset();
    @(posedge clk);
    #1;
    // This first edge is the first counted cycle after release.
    edges = 1;
    exp_tick = ((edges % CLK_DIV) == CLK_DIV - 1);
    check("post_rst_tick", tick, exp_tick);
    check("post_rst_valid", cmd_valid, 0);
  endtask

  initial begin
    int first_tick;
    reset = 1; byte_in = 0; byte_load = 0; cmd_ready = 0;
    model_reset();
    #12;
    do_reset();

    // Clean frame
    valid_rises = 0;
    send_frame(8'h12, 8'h34, 8'h26, 1);
    check("clean_valid", cmd_valid, 1);
    check("clean_cmd", cmd, 8'h12);
    check("clean_arg", arg, 8'h34);
    step(0, 0, 1);
    check("clean_valid_clears", cmd_valid, 0);
    check("clean_err", err_cnt, 0);

    // Bad checksum, then a good frame
    send_frame(8'h12, 8'h34, 8'h00, 1);
    step(0, 0, 1);
    check("bad_no_valid", cmd_valid, 0);
    check("bad_err", err_cnt, 1);
    send_frame(8'h01, 8'h02, 8'h03, 1);
    check("after_bad_cmd", cmd, 8'h01);
    check("after_bad_arg", arg, 8'h02);
    step(0, 0, 1);

    // Back-pressure
    ovr_seen = 0;
    send_frame(8'h12, 8'h34, 8'h26, 0);
    send_frame(8'h55, 8'hAA, 8'hFF, 0);
    step(0, 0, 0);
    check("bp_ovr_once", ovr_seen, 1);
    check("bp_cmd_held", cmd, 8'h12);
    check("bp_valid_held", cmd_valid, 1);
    step(0, 0, 1);
    check("bp_drained", cmd_valid, 0);
    send_frame(8'h55, 8'hAA, 8'hFF, 0);
    check("bp_refill_cmd", cmd, 8'h55);
    check("bp_refill_arg", arg, 8'hAA);
    step(0, 0, 1);

    // Noise before a frame, then saturation
    send_byte(8'h00, 1);
    send_byte(8'hFF, 1);
    send_byte(8'hA4, 1);
    check("noise_err", err_cnt, 1);
    send_frame(8'h77, 8'h08, 8'h7F, 1);
    check("noise_frame_cmd", cmd, 8'h77);
    for (int i = 0; i < 300; i++) send_frame(8'h10, 8'h20, 8'h31, 1);
    step(0, 0, 1);
    check("sat_err", err_cnt, 8'hFF);

    // Randomized mix of good, bad and noise traffic with random back-pressure
    do_reset();
    for (int i = 0; i < 150; i++) begin
      logic [7:0] c, a;
      int kind;
      bit rdy;
      c = 8'($urandom); a = 8'($urandom);
      kind = $urandom_range(0, 9);
      rdy = ($urandom_range(0, 3) != 0);
      if (kind < 7)      send_frame(c, a, c ^ a, rdy);
      else if (kind < 9) send_frame(c, a, (c ^ a) ^ 8'h5A, rdy);
      else               send_byte(8'($urandom), rdy);
    end
    step(0, 0, 1);

    // Stalled partial frame
    do_reset();
    send_byte(SYNC, 1);
    send_byte(8'h12, 1);
    for (int i = 0; i < TIMEOUT_TICKS * CLK_DIV + 20; i++) step(0, 0, 1);
`ifdef RX_FRAME_TIMEOUT_EN
    check("timeout_err", err_cnt, 1);
    send_frame(8'h01, 8'h02, 8'h03, 1);
    check("timeout_next_cmd", cmd, 8'h01);
`else
    check("no_timeout_err", err_cnt, 0);
    send_byte(8'h34, 1);
    send_byte(8'h26, 1);
    check("late_frame_cmd", cmd, 8'h12);
    check("late_frame_arg", arg, 8'h34);
`endif
    step(0, 0, 1);

    // Reset mid-frame
    send_byte(SYNC, 1);
    send_byte(8'h12, 1);
    do_reset();
    first_tick = -1;
    for (int i = 0; i < CLK_DIV + 2; i++) begin
      step(0, 0, 1);
      if (tick && first_tick < 0) first_tick = int'(edges);
    end
    // tick appears in the CLK_DIV-th cycle after release (div_cnt = CLK_DIV-1).
    check("tick_restart", first_tick, CLK_DIV - 1);
    valid_rises = 0;
    send_byte(8'h34, 1);
    send_byte(8'h26, 1);
    step(0, 0, 1);
    check("midrst_no_cmd", valid_rises, 0);
    check("midrst_err", err_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #5000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule : tb_rx_frame_ctrl
